// File: rtl/dec_stream_if.sv
// Valid/ready stream bundle for dec_stream: code in, one-hot word out.
// Optional DEC_STREAM_PARITY_EN adds in_par / out_err.
interface dec_stream_if #(
   parameter int IN_W = 2
) ();
   localparam int OUT_W = 1 << IN_W;

   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_code;
   logic             in_en;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_onehot;
`ifdef DEC_STREAM_PARITY_EN
   logic             in_par;
   logic             out_err;

   modport master (output in_valid, in_code, in_en, in_par, out_ready,
                   input  in_ready, out_valid, out_onehot, out_err);
   modport slave  (input  in_valid, in_code, in_en, in_par, out_ready,
                   output in_ready, out_valid, out_onehot, out_err);
`else
   modport master (output in_valid, in_code, in_en, out_ready,
                   input  in_ready, out_valid, out_onehot);
   modport slave  (input  in_valid, in_code, in_en, out_ready,
                   output in_ready, out_valid, out_onehot);
`endif
endinterface

// File: rtl/dec_stream.sv
// Registered binary-to-one-hot decoder behind a 2-entry output buffer, with
// sticky hit mask and saturating decode counter. Optional: DEC_STREAM_PARITY_EN.
module dec_stream #(
   parameter  int IN_W  = 2,
   parameter  int CNT_W = 8,
   localparam int OUT_W = 1 << IN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   dec_stream_if.slave      bus,
   output logic [OUT_W-1:0] hit_mask,
   output logic [CNT_W-1:0] dec_count
);

`ifdef DEC_STREAM_PARITY_EN
   typedef struct packed {
      logic             err;
      logic [OUT_W-1:0] word;
   } entry_t;

   function automatic logic par_ok(input logic [IN_W-1:0] code, input logic par);
      return ~(^{code, par});
   endfunction
`else
   typedef struct packed {
      logic [OUT_W-1:0] word;
   } entry_t;
`endif

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   state_t           state_q;
   entry_t           head_q, tail_q, entry_d;
   logic             out_valid_q, in_ready_q;
   logic [OUT_W-1:0] hit_mask_q, hit_mask_d;
   logic [CNT_W-1:0] dec_count_q, dec_count_d;
   logic             accept_s, pop_s, par_ok_s, stat_upd_s;

   // Handshake qualification, entry decode and statistics next-state.
   always_comb begin
      accept_s = bus.in_valid & in_ready_q;
      pop_s    = out_valid_q & bus.out_ready;
`ifdef DEC_STREAM_PARITY_EN
      par_ok_s = par_ok(bus.in_code, bus.in_par);
`else
      par_ok_s = 1'b1;
`endif
      entry_d = '0;
      if (bus.in_en & par_ok_s) begin
         entry_d.word = {{(OUT_W-1){1'b0}}, 1'b1} << bus.in_code;
      end else begin
         entry_d.word = {OUT_W{1'b0}};
      end
`ifdef DEC_STREAM_PARITY_EN
      entry_d.err = ~par_ok_s;
`endif
      stat_upd_s  = accept_s & bus.in_en & par_ok_s;
      hit_mask_d  = hit_mask_q;
      dec_count_d = dec_count_q;
      // clr wins over a same-cycle update
      if (clr) begin
         hit_mask_d  = {OUT_W{1'b0}};
         dec_count_d = {CNT_W{1'b0}};
      end else if (stat_upd_s) begin
         hit_mask_d = hit_mask_q | entry_d.word;
         if (dec_count_q != {CNT_W{1'b1}}) begin
            dec_count_d = dec_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            dec_count_d = dec_count_q;
         end
      end else begin
         hit_mask_d  = hit_mask_q;
         dec_count_d = dec_count_q;
      end
   end

   // Occupancy FSM with registered handshake outputs and buffer storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         head_q      <= '0;
         tail_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept_s) begin
                  head_q      <= entry_d;
                  state_q     <= ONE;
                  out_valid_q <= 1'b1;
               end else begin
                  state_q <= EMPTY;
               end
            end
            ONE: begin
               if (accept_s & ~pop_s) begin
                  tail_q     <= entry_d;
                  state_q    <= TWO;
                  in_ready_q <= 1'b0;
               end else if (pop_s & ~accept_s) begin
                  head_q      <= '0;
                  state_q     <= EMPTY;
                  out_valid_q <= 1'b0;
               end else if (accept_s & pop_s) begin
                  head_q <= entry_d;
               end else begin
                  state_q <= ONE;
               end
            end
            TWO: begin
               if (pop_s) begin
                  head_q     <= tail_q;
                  state_q    <= ONE;
                  in_ready_q <= 1'b1;
               end else begin
                  state_q <= TWO;
               end
            end
            default: begin
               state_q     <= EMPTY;
               head_q      <= '0;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_mask_q  <= {OUT_W{1'b0}};
         dec_count_q <= {CNT_W{1'b0}};
      end else begin
         hit_mask_q  <= hit_mask_d;
         dec_count_q <= dec_count_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_onehot = head_q.word;
`ifdef DEC_STREAM_PARITY_EN
   assign bus.out_err    = head_q.err;
`endif
   assign hit_mask       = hit_mask_q;
   assign dec_count      = dec_count_q;

endmodule
